// File: rtl/state_display_if.sv
// Bundle between the state FSM / board controls and the 7-segment + LED display driver.
// state_valid is a one-cycle strobe with no ready: state_in is taken on every cycle
// state_valid is high and ignored otherwise; brightness is a level, sampled every clock.
interface state_display_if;
    logic [2:0] state_in;
    logic       state_valid;
    logic [3:0] brightness;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
    logic [7:0] leds;
    logic       changed;

    modport master (
        output state_in, state_valid, brightness,
        input  seg, dp, an, leds, changed
    );

    modport slave (
        input  state_in, state_valid, brightness,
        output seg, dp, an, leds, changed
    );
endinterface

// File: rtl/state_display_driver.sv
// Drives a 2-digit multiplexed 7-segment display ("S" + state number) and a one-hot LED bar,
// with PWM dimming and a timed change flash. Optional DISPLAY_WRAP_FLAG_EN lights dp after a 7->0 step.
module state_display_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int FLASH_TIME  = 12500000,
    parameter int CNT_W       = 24
) (
    input  logic              clk,
    input  logic              reset,
    state_display_if.slave    disp
);

    logic [2:0]       shown_state;
    logic             digit_sel;
    logic [CNT_W-1:0] refresh_cnt;
    logic [3:0]       pwm_cnt;
    logic [CNT_W-1:0] flash_cnt;

    logic             pwm_on;
    logic             active;
    logic             new_value;
    logic [6:0]       seg_next;
    logic [1:0]       an_next;
    logic [7:0]       leds_next;
    logic             dp_next;

    function automatic logic [6:0] digit_code(input logic [2:0] v);
        case (v)
            3'd0:    digit_code = 7'h40;
            3'd1:    digit_code = 7'h79;
            3'd2:    digit_code = 7'h24;
            3'd3:    digit_code = 7'h30;
            3'd4:    digit_code = 7'h19;
            3'd5:    digit_code = 7'h12;
            3'd6:    digit_code = 7'h02;
            default: digit_code = 7'h78;
        endcase
    endfunction

`ifdef DISPLAY_WRAP_FLAG_EN
    logic wrap_flag;
`endif

    // The change flash overrides dimming so a transition is always visible.
    always_comb begin
        pwm_on    = (pwm_cnt < disp.brightness);
        active    = pwm_on | (flash_cnt != '0);
        new_value = disp.state_valid && (disp.state_in != shown_state);
        seg_next  = digit_sel ? 7'h12 : digit_code(shown_state);
        an_next   = active ? (digit_sel ? 2'b01 : 2'b10) : 2'b11;
        leds_next = active ? (8'd1 << shown_state) : 8'd0;
`ifdef DISPLAY_WRAP_FLAG_EN
        dp_next   = !(wrap_flag && !digit_sel && active);
`else
        dp_next   = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shown_state  <= 3'd0;
            digit_sel    <= 1'b0;
            refresh_cnt  <= '0;
            pwm_cnt      <= 4'd0;
            flash_cnt    <= '0;
            disp.seg     <= 7'h7F;
            disp.dp      <= 1'b1;
            disp.an      <= 2'b11;
            disp.leds    <= 8'd0;
            disp.changed <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;

            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_sel   <= ~digit_sel;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            if (new_value)
                flash_cnt <= CNT_W'(FLASH_TIME);
            else if (flash_cnt != '0)
                flash_cnt <= flash_cnt - 1'b1;

            if (disp.state_valid)
                shown_state <= disp.state_in;

            // Outputs are built from the registered state, giving one cycle after capture.
            disp.seg     <= seg_next;
            disp.dp      <= dp_next;
            disp.an      <= an_next;
            disp.leds    <= leds_next;
            disp.changed <= (flash_cnt != '0);
        end
    end

`ifdef DISPLAY_WRAP_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset)
            wrap_flag <= 1'b0;
        else if (new_value)
            wrap_flag <= (shown_state == 3'd7) && (disp.state_in == 3'd0);
    end
`endif

endmodule

// File: tb/tb_state_display_driver.sv
// Scoreboard bench for state_display_driver: a cycle-level reference model pushes the expected
// outputs of every clock edge; a separate monitor pops and compares them after the edge.
module tb_state_display_driver;

  localparam int RD = 4;
  localparam int FT = 20;
  localparam int W  = 19;   // {seg[6:0], dp, an[1:0], leds[7:0], changed}

  logic clk;
  logic reset;
  state_display_if dif();

  state_display_driver #(
    .REFRESH_DIV(RD),
    .FLASH_TIME (FT),
    .CNT_W      (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .disp (dif)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0] code_tab [8];
  initial begin
    code_tab[0] = 7'h40; code_tab[1] = 7'h79; code_tab[2] = 7'h24; code_tab[3] = 7'h30;
    code_tab[4] = 7'h19; code_tab[5] = 7'h12; code_tab[6] = 7'h02; code_tab[7] = 7'h78;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: time since reset is the only clock state; the refresh slot and PWM phase
  // fall out of it arithmetically. Flash is tracked as remaining clocks.
  int  k;
  int  m_shown;
  int  m_flash;
  bit  m_wrap;

  initial begin
    k = 0; m_shown = 0; m_flash = 0; m_wrap = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        exp_q.push_back({7'h7F, 1'b1, 2'b11, 8'h00, 1'b0});
        k = 0; m_shown = 0; m_flash = 0; m_wrap = 0;
      end else begin
        bit         dsel;
        bit         act;
        logic [6:0] e_seg;
        logic [1:0] e_an;
        logic [7:0] e_leds;
        bit         e_dp;
        int         vin;
        dsel   = ((k / RD) % 2) == 1;
        act    = ((k % 16) < int'(dif.brightness)) || (m_flash > 0);
        e_seg  = dsel ? 7'h12 : code_tab[m_shown];
        e_an   = !act ? 2'b11 : (dsel ? 2'b01 : 2'b10);
        e_leds = act ? 8'(1 << m_shown) : 8'h00;
`ifdef DISPLAY_WRAP_FLAG_EN
        e_dp   = !(m_wrap && !dsel && act);
`else
        e_dp   = 1'b1;
`endif
        exp_q.push_back({e_seg, e_dp, e_an, e_leds, (m_flash > 0)});
        if (m_flash > 0) m_flash--;
        vin = int'(dif.state_in);
        if (dif.state_valid) begin
          if (vin != m_shown) begin
            m_flash = FT;
            m_wrap  = (m_shown == 7) && (vin == 0);
          end
          m_shown = vin;
        end
        k++;
      end
    end
  end

  // Monitor: the display presents a fresh output word every clock.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        check("queue_empty", 8'd0, 8'd1);
      end else begin
        e = exp_q.pop_front();
        check("seg",     {1'b0, dif.seg}, {1'b0, e[18:12]});
        check("dp",      {7'd0, dif.dp},  {7'd0, e[11]});
        check("an",      {6'd0, dif.an},  {6'd0, e[10:9]});
        check("leds",    dif.leds,        e[8:1]);
        check("changed", {7'd0, dif.changed}, {7'd0, e[0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      // state_in carries junk whenever no strobe is presented
      dif.state_in = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic strobe(input int v);
    @(posedge clk);
    #1;
    dif.state_valid = 1'b1;
    dif.state_in    = 3'(v);
    @(posedge clk);
    #1;
    dif.state_valid = 1'b0;
    dif.state_in    = 3'($urandom_range(0, 7));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset           = 1'b1;
    dif.state_in    = 3'd0;
    dif.state_valid = 1'b0;
    dif.brightness  = 4'd15;
    tick(3);
    reset = 1'b0;

    // Refresh alternation at full brightness
    tick(20);

    // Change flash and a repeated equal strobe inside it
    strobe(3);
    tick(8);
    strobe(3);
    tick(25);

    // PWM duty, fully dark, then flash while dark
    dif.brightness = 4'd4;
    tick(40);
    dif.brightness = 4'd0;
    tick(20);
    strobe(5);
    tick(35);

    // Flash reload by a second different value
    dif.brightness = 4'd15;
    strobe(2);
    tick(24);
    strobe(5);
    tick(8);
    strobe(6);
    tick(35);

    // Full step sequence through the 7->0 wrap, then clear with 1
    for (int s = 0; s <= 8; s++) begin
      strobe(s % 8);
      tick(3);
    end
    tick(12);
    strobe(1);
    tick(12);

    // Reset in the middle of a flash
    strobe(4);
    tick(5);
    do_reset(1);
    tick(10);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      dif.state_valid = ($urandom_range(0, 7) == 0);
      dif.state_in    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0)
        dif.brightness = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0)
        reset = 1'b1;
      else
        reset = 1'b0;
    end
    @(posedge clk);
    #1;
    dif.state_valid = 1'b0;
    reset = 1'b0;
    tick(30);

    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
